// File: rtl/load_cache_responder_pkg.sv
// Shared constants for the load data-cache responder: default widths, refill stall and FSM encodings.
package load_cache_responder_pkg;

    localparam int unsigned DEF_WORD_SIZE  = 32;
    localparam int unsigned DEF_INDEX_BITS = 4;
    localparam int unsigned DEF_MEM_STALL  = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_FILL = 1'b1;

endpackage

// File: rtl/load_cache_responder_if.sv
// Load RS / backing memory / store-invalidate port of the data cache, viewed from either side.
interface load_cache_responder_if
    import load_cache_responder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_SIZE
);
    logic [WIDTH-1:0] c_ptr;
    logic             c_read_enable;
    logic [WIDTH-1:0] c_out;
    logic             c_hit;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             inval_enable;
    logic [WIDTH-1:0] inval_ptr;

    // Requester side: load RS plus the backing memory model.
    modport master (
        output c_ptr, c_read_enable, mem_rdata, inval_enable, inval_ptr,
        input  c_out, c_hit, mem_addr
    );

    modport slave (
        input  c_ptr, c_read_enable, mem_rdata, inval_enable, inval_ptr,
        output c_out, c_hit, mem_addr
    );
endinterface

// File: rtl/load_cache_responder_dcache_array.sv
// Direct-mapped valid/tag/data storage: async read, sync write, tag-checked invalidate, async clear on reset.
module dcache_array
    import load_cache_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [INDEX_BITS-1:0]             rd_index,
    output logic                              rd_valid,
    output logic [WORD_SIZE-INDEX_BITS-1:0]   rd_tag,
    output logic [WORD_SIZE-1:0]              rd_data,
    input  logic                              wr_en,
    input  logic [INDEX_BITS-1:0]             wr_index,
    input  logic [WORD_SIZE-INDEX_BITS-1:0]   wr_tag,
    input  logic [WORD_SIZE-1:0]              wr_data,
    input  logic                              wr_valid,
    input  logic                              inval_en,
    input  logic [INDEX_BITS-1:0]             inval_index,
    input  logic [WORD_SIZE-INDEX_BITS-1:0]   inval_tag
);
    localparam int unsigned LINES    = 2 ** INDEX_BITS;
    localparam int unsigned TAG_BITS = WORD_SIZE - INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_SIZE-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // A refill to the invalidated line lands after the clear, so the caller decides its valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (inval_en && (tag_q[inval_index] == inval_tag)) begin
                valid_q[inval_index] <= 1'b0;
            end
            if (wr_en) begin
                valid_q[wr_index] <= wr_valid;
                tag_q[wr_index]   <= wr_tag;
                data_q[wr_index]  <= wr_data;
            end
        end
    end
endmodule

// File: rtl/load_cache_responder.sv
// Data-cache responder for load RSs: registered c_out/c_hit, refill on miss with MEM_STALL busy cycles,
// store-path invalidate and saturating hit/miss statistics.
module load_cache_responder
    import load_cache_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned MEM_STALL  = DEF_MEM_STALL,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    load_cache_responder_if.slave        bus,
    output logic [CNT_WIDTH-1:0]         hit_count,
    output logic [CNT_WIDTH-1:0]         miss_count
);
    localparam int unsigned TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int unsigned FILL_W   = (MEM_STALL > 1) ? $clog2(MEM_STALL) : 1;

    logic [0:0]           state_q,   state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic                 req_held_q, req_held_d;
    logic [WORD_SIZE-1:0] c_out_q,   c_out_d;
    logic                 c_hit_q,   c_hit_d;
    logic [CNT_WIDTH-1:0] hit_cnt_d, miss_cnt_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [WORD_SIZE-1:0]  line_data;
    logic                  same_inval_c;
    logic                  lookup_hit_c;
    logic                  accept_c;
    logic                  refill_c;

    assign req_index    = bus.c_ptr[INDEX_BITS-1:0];
    assign req_tag      = bus.c_ptr[WORD_SIZE-1:INDEX_BITS];
    assign bus.mem_addr = bus.c_ptr;
    assign bus.c_out    = c_out_q;
    assign bus.c_hit    = c_hit_q;

    // An invalidate of the requested word on the accept edge wins over the stored line.
    assign same_inval_c = bus.inval_enable && (bus.inval_ptr == bus.c_ptr);
    assign lookup_hit_c = line_valid && (line_tag == req_tag) && !same_inval_c;
    assign accept_c     = (state_q == C_IDLE) && bus.c_read_enable && !req_held_q;

    dcache_array #(
        .WORD_SIZE  (WORD_SIZE),
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (req_index),
        .rd_valid    (line_valid),
        .rd_tag      (line_tag),
        .rd_data     (line_data),
        .wr_en       (refill_c),
        .wr_index    (req_index),
        .wr_tag      (req_tag),
        .wr_data     (bus.mem_rdata),
        .wr_valid    (!same_inval_c),
        .inval_en    (bus.inval_enable),
        .inval_index (bus.inval_ptr[INDEX_BITS-1:0]),
        .inval_tag   (bus.inval_ptr[WORD_SIZE-1:INDEX_BITS])
    );

    // Next-state, response and statistics logic.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        req_held_d = req_held_q;
        c_out_d    = c_out_q;
        c_hit_d    = c_hit_q;
        hit_cnt_d  = hit_count;
        miss_cnt_d = miss_count;
        refill_c   = 1'b0;

        if (!bus.c_read_enable) begin
            req_held_d = 1'b0;
        end

        case (state_q)
            C_IDLE: begin
                if (accept_c) begin
                    req_held_d = 1'b1;
                    if (lookup_hit_c) begin
                        c_out_d = line_data;
                        c_hit_d = 1'b1;
                        if (hit_count != '1) hit_cnt_d = hit_count + CNT_WIDTH'(1);
                    end else begin
                        c_out_d    = bus.mem_rdata;
                        c_hit_d    = 1'b0;
                        refill_c   = 1'b1;
                        state_d    = C_FILL;
                        fill_cnt_d = FILL_W'(MEM_STALL - 1);
                        if (miss_count != '1) miss_cnt_d = miss_count + CNT_WIDTH'(1);
                    end
                end
            end
            // Leaving on the edge where the count runs out lets the next accept land MEM_STALL edges after the miss.
            C_FILL: begin
                if (fill_cnt_q <= FILL_W'(1)) begin
                    state_d    = C_IDLE;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q - FILL_W'(1);
                end
            end
            default: begin
                state_d    = C_IDLE;
                fill_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= C_IDLE;
            fill_cnt_q <= '0;
            req_held_q <= 1'b0;
            c_out_q    <= '0;
            c_hit_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            req_held_q <= req_held_d;
            c_out_q    <= c_out_d;
            c_hit_q    <= c_hit_d;
            hit_count  <= hit_cnt_d;
            miss_count <= miss_cnt_d;
        end
    end
endmodule
